// File: rtl/median_ctrl_pkg.sv
// Shared definitions for the median-filter control slice: frame geometry,
// FSM state encodings, window step values and the registered-state strobe bundle.
package median_ctrl_pkg;

    localparam int LENGTH = 480;
    localparam int WIDTH  = 640;

    localparam int STEP_W  = 3;
    localparam int WAIT_W  = 2;
    localparam int FSTEP_W = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_IMG    = 3'd3;
    localparam logic [2:0] S_FILT   = 3'd4;
    localparam logic [2:0] S_EMIT   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    // Window address/register pair selects; 0 leaves the datapath untouched.
    localparam logic [STEP_W-1:0] STEP_NOP   = 3'd0;
    localparam logic [STEP_W-1:0] STEP_FIRST = 3'd1;
    localparam logic [STEP_W-1:0] STEP_LAST  = 3'd5;

    typedef struct packed {
        logic               ld_addr;
        logic [STEP_W-1:0]  sel_addr;
        logic               ld_image;
        logic [STEP_W-1:0]  sel_image;
        logic               ld_filter;
        logic [FSTEP_W-1:0] sel_filter;
        logic               done;
        logic               busy;
        logic               frame_done;
    } strobes_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_step_cnt.sv
// Generic up-counter with synchronous clear and a terminal-count flag.
module median_step_cnt
    import median_ctrl_pkg::*;
#(
    parameter int W        = 2,
    parameter int TERMINAL = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/median_ctrl.sv
// Sequencing FSM for the median-filter datapath: 3x3 window fetch, comparator
// stepping, per-pixel done/pix_valid handshake and frame start/finish control.
module median_ctrl
    import median_ctrl_pkg::*;
#(
    parameter int NUM_PIXELS   = WIDTH * LENGTH,
    parameter int RAM_LAT      = 2,
    parameter int FILTER_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out_ready,
    output logic       ldAddr,
    output logic [2:0] selAddr,
    output logic       ldImage,
    output logic [2:0] selImage,
    output logic       ldFilter,
    output logic [1:0] selFilter,
    output logic       done,
    output logic       pix_valid,
    output logic       busy,
    output logic       frame_done
);

    localparam int PIX_W = cnt_width(NUM_PIXELS);

    logic [2:0]         state, state_nxt;
    logic [STEP_W-1:0]  step, step_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [FSTEP_W-1:0] fstep;
    logic [PIX_W-1:0]   pix_cnt;
    logic               wait_tc, fstep_tc, pix_tc;
    logic               emit_fire;
    strobes_t           strb;

    assign emit_fire = (state == S_EMIT) && out_ready;

    // Counters hold at their terminal value rather than wrapping; each is
    // cleared whenever its owning state is left.
    median_step_cnt #(
        .W        (WAIT_W),
        .TERMINAL (RAM_LAT - 1)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != S_WAIT),
        .en  ((state == S_WAIT) && !wait_tc),
        .cnt (wait_cnt),
        .tc  (wait_tc)
    );

    median_step_cnt #(
        .W        (FSTEP_W),
        .TERMINAL (FILTER_STEPS - 1)
    ) u_fstep_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state != S_FILT),
        .en  ((state == S_FILT) && !fstep_tc),
        .cnt (fstep),
        .tc  (fstep_tc)
    );

    median_step_cnt #(
        .W        (PIX_W),
        .TERMINAL (NUM_PIXELS - 1)
    ) u_pix_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state == S_IDLE),
        .en  (emit_fire && !pix_tc),
        .cnt (pix_cnt),
        .tc  (pix_tc)
    );

    logic unused_cnt_bits;
    assign unused_cnt_bits = ^{wait_cnt, pix_cnt};

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ADDR;
                    step_nxt  = STEP_FIRST;
                end
            end
            S_ADDR:   state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_tc) state_nxt = S_IMG;
            end
            S_IMG: begin
                if (step == STEP_LAST) begin
                    state_nxt = S_FILT;
                end else begin
                    state_nxt = S_ADDR;
                    step_nxt  = step + 3'd1;
                end
            end
            S_FILT: begin
                if (fstep_tc) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (pix_tc) begin
                        state_nxt = S_FINISH;
                    end else begin
                        state_nxt = S_ADDR;
                        step_nxt  = STEP_FIRST;
                    end
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= STEP_NOP;
        end else begin
            state <= state_nxt;
            step  <= step_nxt;
        end
    end

    // Strobes decode the registered state only; done additionally qualifies
    // on out_ready so the writer handshake completes in the EMIT cycle itself.
    always_comb begin
        strb            = '0;
        strb.busy       = (state != S_IDLE);
        strb.ld_addr    = (state == S_ADDR);
        strb.sel_addr   = (state == S_ADDR) ? step : STEP_NOP;
        strb.ld_image   = (state == S_IMG);
        strb.sel_image  = (state == S_IMG) ? step : STEP_NOP;
        strb.ld_filter  = (state == S_FILT);
        strb.sel_filter = (state == S_FILT) ? fstep : '0;
        strb.done       = emit_fire;
        strb.frame_done = (state == S_FINISH);
    end

    assign ldAddr     = strb.ld_addr;
    assign selAddr    = strb.sel_addr;
    assign ldImage    = strb.ld_image;
    assign selImage   = strb.sel_image;
    assign ldFilter   = strb.ld_filter;
    assign selFilter  = strb.sel_filter;
    assign done       = strb.done;
    assign pix_valid  = strb.done;
    assign busy       = strb.busy;
    assign frame_done = strb.frame_done;

endmodule

// File: tb/tb_median_ctrl.sv
// Scoreboard bench for median_ctrl: a default-timing instance (3-pixel frame) and
// a short-latency instance (RAM_LAT=1, FILTER_STEPS=2, 2-pixel frame).
module tb_median_ctrl;

    localparam int K_ADDR  = 0;
    localparam int K_IMG   = 1;
    localparam int K_FILT  = 2;
    localparam int K_DONE  = 3;
    localparam int K_FDONE = 4;

    typedef struct {
        int kind;
        int sel;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start0 = 1'b0, rdy0 = 1'b1, start1 = 1'b0, rdy1 = 1'b1;

    logic       d0_la, d0_li, d0_lf, d0_dn, d0_pv, d0_busy, d0_fd;
    logic [2:0] d0_sa, d0_si;
    logic [1:0] d0_sf;
    logic       d1_la, d1_li, d1_lf, d1_dn, d1_pv, d1_busy, d1_fd;
    logic [2:0] d1_sa, d1_si;
    logic [1:0] d1_sf;

    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[2][$];
    string kname[5] = '{"ldAddr", "ldImage", "ldFilter", "done", "frame_done"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    median_ctrl #(
        .NUM_PIXELS   (3),
        .RAM_LAT      (2),
        .FILTER_STEPS (4)
    ) u_dut0 (
        .clk (clk), .rst (rst), .start (start0), .out_ready (rdy0),
        .ldAddr (d0_la), .selAddr (d0_sa), .ldImage (d0_li), .selImage (d0_si),
        .ldFilter (d0_lf), .selFilter (d0_sf), .done (d0_dn), .pix_valid (d0_pv),
        .busy (d0_busy), .frame_done (d0_fd)
    );

    median_ctrl #(
        .NUM_PIXELS   (2),
        .RAM_LAT      (1),
        .FILTER_STEPS (2)
    ) u_dut1 (
        .clk (clk), .rst (rst), .start (start1), .out_ready (rdy1),
        .ldAddr (d1_la), .selAddr (d1_sa), .ldImage (d1_li), .selImage (d1_si),
        .ldFilter (d1_lf), .selFilter (d1_sf), .done (d1_dn), .pix_valid (d1_pv),
        .busy (d1_busy), .frame_done (d1_fd)
    );

    function automatic ev_t mk(input int kind, input int sel, input int c);
        ev_t e;
        e.kind = kind;
        e.sel  = sel;
        e.cyc  = c;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    // Pixel starting with ldAddr at cycle b; done expected at cycle d.
    task automatic push_pixel(input int i, input int b, input int lat, input int fs, input int d);
        for (int k = 1; k <= 5; k++) begin
            exp_q[i].push_back(mk(K_ADDR, k, b + (k - 1) * (lat + 2)));
            exp_q[i].push_back(mk(K_IMG,  k, b + (k - 1) * (lat + 2) + lat + 1));
        end
        for (int j = 0; j < fs; j++)
            exp_q[i].push_back(mk(K_FILT, j, b + 5 * (lat + 2) + j));
        exp_q[i].push_back(mk(K_DONE, 0, d));
    endtask

    task automatic observe(input int i, input logic la, input logic [2:0] sa,
                           input logic li, input logic [2:0] si, input logic lf,
                           input logic [1:0] sf, input logic dn, input logic pv,
                           input logic fd);
        int  nact, kind, sel;
        ev_t e;
        nact = int'(la) + int'(li) + int'(lf) + int'(dn) + int'(fd);
        n_cmp++;
        if ((!la && sa != 3'd0) || (!li && si != 3'd0) || (!lf && sf != 2'd0) ||
            (pv != dn) || (nact > 1)) begin
            n_bad++;
            $display("FAIL strobe_form[%0d] cyc %0d: ld=%b%b%b sel=%0d/%0d/%0d done=%b pix_valid=%b frame_done=%b, required <=1 strobe, idle sels 0, pix_valid==done",
                     i, cyc, la, li, lf, sa, si, sf, dn, pv, fd);
        end
        if (nact == 0) return;
        kind = la ? K_ADDR : li ? K_IMG : lf ? K_FILT : dn ? K_DONE : K_FDONE;
        sel  = la ? int'(sa) : li ? int'(si) : lf ? int'(sf) : 0;
        n_cmp++;
        if (exp_q[i].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event[%0d]: got %s sel %0d at cyc %0d, required none",
                     i, kname[kind], sel, cyc);
            return;
        end
        e = exp_q[i].pop_front();
        if (e.kind != kind || e.sel != sel || e.cyc != cyc) begin
            n_bad++;
            $display("FAIL event[%0d]: got %s sel %0d at cyc %0d, required %s sel %0d at cyc %0d",
                     i, kname[kind], sel, cyc, kname[e.kind], e.sel, e.cyc);
        end
    endtask

    always @(negedge clk) observe(0, d0_la, d0_sa, d0_li, d0_si, d0_lf, d0_sf, d0_dn, d0_pv, d0_fd);
    always @(negedge clk) observe(1, d1_la, d1_sa, d1_li, d1_si, d1_lf, d1_sf, d1_dn, d1_pv, d1_fd);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame3(input int b);
        push_pixel(0, b, 2, 4, b + 24);
        push_pixel(0, b + 25, 2, 4, b + 49);
        push_pixel(0, b + 50, 2, 4, b + 74);
        exp_q[0].push_back(mk(K_FDONE, 0, b + 75));
    endtask

    initial begin
        int b;
        #1 rst = 1'b1;
        tick();
        tick();
        check("rst_ldAddr",     d0_la, 0);
        check("rst_selAddr",    d0_sa, 0);
        check("rst_ldImage",    d0_li, 0);
        check("rst_selImage",   d0_si, 0);
        check("rst_ldFilter",   d0_lf, 0);
        check("rst_selFilter",  d0_sf, 0);
        check("rst_done",       d0_dn, 0);
        check("rst_pix_valid",  d0_pv, 0);
        check("rst_busy",       d0_busy, 0);
        check("rst_frame_done", d0_fd, 0);
        check("rst_dut1_all",   int'({d1_la, d1_sa, d1_li, d1_si, d1_lf, d1_sf, d1_dn, d1_pv, d1_busy, d1_fd}), 0);
        rst = 1'b0;
        tick();
        tick();

        // Full frame at ready=1, with start pulses mid-frame and on the FINISH cycle.
        start0 = 1'b1;
        b = cyc + 1;
        push_frame3(b);
        tick();
        while (cyc < b + 78) begin
            start0 = (cyc == b + 10 || cyc == b + 40 || cyc == b + 60 || cyc == b + 75);
            #2;
            if (cyc == b + 5 || cyc == b + 75) check("busy_in_frame", d0_busy, 1);
            if (cyc == b + 76) check("busy_after_finish", d0_busy, 0);
            tick();
        end
        start0 = 1'b0;
        check("queue0_drained_frame1", exp_q[0].size(), 0);

        // Writer back-pressure: ten EMIT cycles with out_ready low on pixel 1.
        start0 = 1'b1;
        b = cyc + 1;
        push_pixel(0, b, 2, 4, b + 34);
        push_pixel(0, b + 35, 2, 4, b + 59);
        push_pixel(0, b + 60, 2, 4, b + 84);
        exp_q[0].push_back(mk(K_FDONE, 0, b + 85));
        tick();
        start0 = 1'b0;
        while (cyc < b + 88) begin
            rdy0 = !(cyc >= b + 20 && cyc < b + 34);
            #2;
            if (cyc >= b + 24 && cyc < b + 34) begin
                check("stall_done", d0_dn, 0);
                check("stall_strobes", int'({d0_la, d0_li, d0_lf, d0_fd}), 0);
            end
            if (cyc == b + 34) check("ready_done_same_cycle", d0_dn, 1);
            if (cyc == b + 35) check("addr_after_emit", d0_la, 1);
            tick();
        end
        rdy0 = 1'b1;
        check("queue0_drained_stall", exp_q[0].size(), 0);

        // Reset during WAIT of pixel 2 drops the partial pixel.
        start0 = 1'b1;
        b = cyc + 1;
        push_pixel(0, b, 2, 4, b + 24);
        exp_q[0].push_back(mk(K_ADDR, 1, b + 25));
        tick();
        start0 = 1'b0;
        while (cyc < b + 26) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", d0_busy, 0);
        check("midrst_outputs", int'({d0_la, d0_sa, d0_li, d0_si, d0_lf, d0_sf, d0_dn, d0_pv, d0_fd}), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("queue0_drained_midrst", exp_q[0].size(), 0);
        start0 = 1'b1;
        b = cyc + 1;
        push_frame3(b);
        tick();
        start0 = 1'b0;
        while (cyc < b + 78) tick();
        check("queue0_drained_restart", exp_q[0].size(), 0);

        // Short-latency instance: 18-cycle pixel period, selFilter 0..1.
        start1 = 1'b1;
        b = cyc + 1;
        push_pixel(1, b, 1, 2, b + 17);
        push_pixel(1, b + 18, 1, 2, b + 35);
        exp_q[1].push_back(mk(K_FDONE, 0, b + 36));
        tick();
        start1 = 1'b0;
        while (cyc < b + 40) begin
            #2;
            if (cyc == b + 37) check("busy1_idle", d1_busy, 0);
            tick();
        end
        check("queue1_drained", exp_q[1].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: bench still running at cyc %0d, required completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
